rr_arbiter8: RTL and testbench

//   Round-robin arbiter granting one shared resource to one of 8 requesters.

---
 rtl/rr_arbiter8.sv | 135 +++++++++++++
 tb/tb_rr_arbiter8.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters, one-hot + encoded grant.
// Ports: clk, rst (sync, active-high), req[7:0], done -> gnt[7:0], gnt_idx[2:0],
//   gnt_valid, timeout. Define ARB_TIMEOUT_EN to enable the MAX_HOLD forced release.
module rr_arbiter8 #(
  parameter int NREQ = 8
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            vld_q, vld_d;
  logic            to_q, to_d;
  logic [2:0]      sel;
  logic [2:0]      scan;
  logic            found;
  logic            rel;

`ifdef ARB_TIMEOUT_EN
  localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);
  logic [4:0] cnt_q, cnt_d;
`endif

  // circular scan starting at ptr; first hit wins
  always_comb begin
    sel   = '0;
    scan  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      scan = ptr_q + 3'(i);
      if (!found && req[scan]) begin
        sel   = scan;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    to_d    = 1'b0;
    rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = GRANT;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          idx_d      = sel;
          vld_d      = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (done || !req[idx_q]) begin
          rel = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == HOLD_LAST) begin
          rel  = 1'b1;
          to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
`endif
        end
        if (rel) begin
          state_d = IDLE;
          ptr_d   = idx_q + 3'd1;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      to_q    <= to_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = vld_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = to_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench for rr_arbiter8.
// Directed scenarios then random req/done/rst against a reference model.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter8 dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // reference model: who owns the resource, where the scan starts next
  bit m_busy  = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 0;

  function automatic int pick(input logic [7:0] r, input int p);
    int best = -1;
    int bdist = 99;
    for (int i = 0; i < 8; i++)
      if (r[i] && ((i - p + 8) % 8) < bdist) begin
        bdist = (i - p + 8) % 8;
        best  = i;
      end
    return best;
  endfunction

  task automatic model(input bit rs, input logic [7:0] r, input bit d);
    int w;
    m_to = 0;
    if (rs) begin
      m_busy = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_held = 0;
      end
    end else begin
      m_held++;
      if (d || !r[m_owner]) begin
        m_busy = 0; m_ptr = (m_owner + 1) % 8;
`ifdef ARB_TIMEOUT_EN
      end else if (m_held == 16) begin
        m_busy = 0; m_ptr = (m_owner + 1) % 8; m_to = 1;
`endif
      end
    end
  endtask

  task automatic step(input bit rs, input logic [7:0] r, input bit d);
    exp_t e;
    rst = rs; req = r; done = d;
    model(rs, r, d);
    e.gnt = m_busy ? 8'(1 << m_owner) : 8'h00;
    e.idx = m_busy ? 3'(m_owner) : 3'd0;
    e.vld = m_busy;
    e.to  = m_to;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, a, x);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt", gnt, e.gnt);
      chk("gnt_idx", 8'(gnt_idx), 8'(e.idx));
      chk("gnt_valid", 8'(gnt_valid), 8'(e.vld));
      chk("timeout", 8'(timeout), 8'(e.to));
    end
  end

  initial begin
    logic [7:0] r;
    // reset with all requests high
    step(1, 8'hFF, 0);
    step(1, 8'hFF, 0);
    // single request, release by done -> ptr 5
    step(0, 8'h10, 0);
    step(0, 8'h10, 0);
    step(0, 8'h10, 1);
    step(0, 8'h00, 0);
    // ptr 5, req 09 -> idx 0 then idx 3
    step(0, 8'h09, 0);
    step(0, 8'h09, 1);
    step(0, 8'h09, 0);
    step(0, 8'h09, 1);
    step(0, 8'h00, 0);
    // full rotation with wrap
    step(1, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 8'hFF, 0);
      step(0, 8'hFF, 1);
    end
    // withdrawal release, then reset mid-grant
    step(1, 8'h00, 0);
    step(0, 8'h04, 0);
    step(0, 8'h04, 0);
    step(0, 8'h00, 0);
    step(0, 8'h04, 0);
    step(0, 8'h04, 0);
    step(1, 8'h04, 0);
    step(0, 8'h00, 0);
    // long hold: forced release only with the timeout feature
    for (int i = 0; i < 22; i++) step(0, 8'h01, 0);
    step(0, 8'h00, 0);
    // done while idle is ignored
    step(0, 8'h00, 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      step($urandom_range(0, 63) == 0, r,
           $urandom_range(0, 5) == 0);
    end
    for (int k = 0; k < 4 && sb.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
